sha_msg_schedule: RTL

//  Sequential, parametrised SHA-2 message-schedule expander. Accepts one 16-word padded block.

---
 rtl/sha_pkg.sv | 32 +++
 rtl/sha_sched_sigma.sv | 29 ++
 rtl/sha_msg_schedule.sv | 104 ++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-2 message-schedule expander.
package sha_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned SHA512_ROUNDS = 80;

  // Rotate/shift amounts for the small sigma functions s0 and s1
  typedef struct packed {
    int unsigned r0a;
    int unsigned r0b;
    int unsigned sh0;
    int unsigned r1a;
    int unsigned r1b;
    int unsigned sh1;
  } sigma_cfg_t;

  // Entry 0: 32-bit words (SHA-256), entry 1: 64-bit words (SHA-512)
  localparam sigma_cfg_t SIGMA_TBL [2] = '{
    '{r0a: 7, r0b: 18, sh0: 3, r1a: 17, r1b: 19, sh1: 10},
    '{r0a: 1, r0b: 8,  sh0: 7, r1a: 19, r1b: 61, sh1: 6}
  };

  function automatic sigma_cfg_t sigma_cfg(input int unsigned word_w);
    return SIGMA_TBL[word_w == 64 ? 1 : 0];
  endfunction

endpackage

// File: rtl/sha_sched_sigma.sv
// Next schedule word: s1(w14) + w9 + s0(w1) + w0, modulo 2^WORD_W.
module sha_sched_sigma
  import sha_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_next_c
);

  localparam sigma_cfg_t CFG = sigma_cfg(WORD_W);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  always_comb begin
    s0       = rotr(w1, CFG.r0a) ^ rotr(w1, CFG.r0b) ^ (w1 >> CFG.sh0);
    s1       = rotr(w14, CFG.r1a) ^ rotr(w14, CFG.r1b) ^ (w14 >> CFG.sh1);
    w_next_c = s1 + w9 + s0 + w0;
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander: loads a 16-word block, streams W[0..ROUNDS-1].
// Optional build macro SHA_SCHED_BYTESWAP_EN byte-reverses each word at load.
module sha_msg_schedule
  import sha_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = SHA256_ROUNDS
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_blk_valid,
  output logic                        o_blk_ready,
  input  logic [16*WORD_W-1:0]        i_block,
  output logic                        o_w_valid,
  input  logic                        i_w_ready,
  output logic [WORD_W-1:0]           o_w,
  output logic [$clog2(ROUNDS)-1:0]   o_w_idx,
  output logic                        o_w_last
);

  localparam int unsigned IDX_W    = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] w_next;
  logic              load;
  logic              shift;

  function automatic logic [WORD_W-1:0] load_word(input logic [WORD_W-1:0] x);
`ifdef SHA_SCHED_BYTESWAP_EN
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[8*b +: 8] = x[WORD_W-8-8*b +: 8];
    end
    return r;
`else
    return x;
`endif
  endfunction

  sha_sched_sigma #(.WORD_W(WORD_W)) u_sigma (
    .w0       (win_q[0]),
    .w1       (win_q[1]),
    .w9       (win_q[9]),
    .w14      (win_q[14]),
    .w_next_c (w_next)
  );

  assign load  = (state_q == IDLE) & i_blk_valid;
  assign shift = (state_q == RUN) & i_w_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin : state_reg
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Clear overrides both the block load and the word handshake
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE: if (i_blk_valid) state_d = RUN;
      RUN:  if (i_w_ready && (idx_q == LAST_IDX)) state_d = IDLE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  // Sliding window: W[t] sits in win_q[0]; the new word enters at the top on each shift
  always_ff @(posedge i_clk or posedge i_reset) begin : window_reg
    if (i_reset) begin
      for (int k = 0; k < 16; k++) win_q[k] <= '0;
      idx_q <= '0;
    end else if (i_clear) begin
      idx_q <= '0;
    end else if (load) begin
      for (int k = 0; k < 16; k++) win_q[k] <= load_word(i_block[(15-k)*WORD_W +: WORD_W]);
      idx_q <= '0;
    end else if (shift) begin
      for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
      win_q[15] <= w_next;
      idx_q     <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin : outputs
    o_blk_ready = 1'b0;
    o_w_valid   = 1'b0;
    o_w_last    = 1'b0;
    o_w         = win_q[0];
    o_w_idx     = idx_q;
    case (state_q)
      IDLE: o_blk_ready = 1'b1;
      RUN: begin
        o_w_valid = 1'b1;
        o_w_last  = (idx_q == LAST_IDX);
      end
    endcase
  end

endmodule
